// File: rtl/gin.sv
// -----------------------------------------------------------------------------
// gin - Global Input Network
//
// Tag-based multicast of one data word from a single source to a
// Y_BUS_SIZE x X_BUS_SIZE array of processing elements. A Y bus of multicast
// controllers (MCs) selects rows by row_tag. A per-row X bus of MCs selects
// columns by col_tag. All MC ID registers form one serial scan chain.
//
// Optional feature (compile-time macro GIN_TAG_WILDCARD_EN):
//   defined   - an ID register holding all ones matches any incoming tag
//   undefined - exact-equality matching only
//
// Ports:
//   clk           clock
//   rstb          asynchronous active-low reset
//   program_en    scan-chain shift enable. The name "program" is a reserved
//                 SystemVerilog keyword, so the enable carries this name.
//   scan_tag_in   serial tag entering the chain
//   scan_tag_out  tag leaving the end of the chain (ybus.mc[0] ID)
//   gin_enable    source has a valid packet
//   gin_ready     all addressed PEs can accept (combinational)
//   data_packet   {row_tag, col_tag, data}, row_tag in the MSBs
//   pe_enable     per-PE write strobe, k = row*X_BUS_SIZE + col (combinational)
//   pe_ready      per-PE ready, same indexing
//   pe_value      per-PE data, slice k at [BITWIDTH*k +: BITWIDTH]
// -----------------------------------------------------------------------------
module gin #(
    parameter int BITWIDTH   = 16,
    parameter int TAG_LENGTH = 4,
    parameter int X_BUS_SIZE = 4,
    parameter int Y_BUS_SIZE = 4
) (
    input  logic                                       clk,
    input  logic                                       rstb,
    input  logic                                       program_en,
    input  logic [TAG_LENGTH-1:0]                      scan_tag_in,
    output logic [TAG_LENGTH-1:0]                      scan_tag_out,
    input  logic                                       gin_enable,
    output logic                                       gin_ready,
    input  logic [2*TAG_LENGTH+BITWIDTH-1:0]           data_packet,
    output logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]           pe_enable,
    input  logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]           pe_ready,
    output logic [BITWIDTH*X_BUS_SIZE*Y_BUS_SIZE-1:0]  pe_value
);

    localparam int NUM_PE    = X_BUS_SIZE * Y_BUS_SIZE;
    localparam int CHAIN_LEN = Y_BUS_SIZE + NUM_PE;
    localparam int PKT_W     = 2 * TAG_LENGTH + BITWIDTH;

    // Chain index 0 is ybus.mc[0] (output end); index r is ybus.mc[r];
    // index Y_BUS_SIZE + r*X_BUS_SIZE + c is xbus[r].mc[c]. Shifting moves
    // each word toward index 0, so the first word pushed ends up in ybus.mc[0].
    logic [TAG_LENGTH-1:0] chain_r [CHAIN_LEN];

    logic [TAG_LENGTH-1:0] row_tag_s;
    logic [TAG_LENGTH-1:0] col_tag_s;
    logic [BITWIDTH-1:0]   data_s;
    logic [NUM_PE-1:0]     hit_s;
    logic                  ready_s;
    logic [NUM_PE-1:0]     enable_s;

    // Tag comparison shared by both bus levels; all-ones is a wildcard
    // only when the feature is compiled in.
    function automatic logic tag_match(input logic [TAG_LENGTH-1:0] id,
                                       input logic [TAG_LENGTH-1:0] tag);
`ifdef GIN_TAG_WILDCARD_EN
        return (id == tag) || (&id);
`else
        return (id == tag);
`endif
    endfunction

    assign row_tag_s = data_packet[PKT_W-1 -: TAG_LENGTH];
    assign col_tag_s = data_packet[BITWIDTH +: TAG_LENGTH];
    assign data_s    = data_packet[BITWIDTH-1:0];

    // Scan chain: shift one position toward the output on program_en.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                chain_r[i] <= {TAG_LENGTH{1'b0}};
            end
        end else if (program_en) begin
            for (int i = 0; i < CHAIN_LEN - 1; i++) begin
                chain_r[i] <= chain_r[i+1];
            end
            chain_r[CHAIN_LEN-1] <= scan_tag_in;
        end else begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                chain_r[i] <= chain_r[i];
            end
        end
    end

    // Per-PE hit: row MC match ANDed with the column MC match in that row.
    always_comb begin
        hit_s = {NUM_PE{1'b0}};
        for (int r = 0; r < Y_BUS_SIZE; r++) begin
            for (int c = 0; c < X_BUS_SIZE; c++) begin
                hit_s[r*X_BUS_SIZE+c] = tag_match(chain_r[r], row_tag_s) &
                    tag_match(chain_r[Y_BUS_SIZE+r*X_BUS_SIZE+c], col_tag_s);
            end
        end
    end

    // All-or-nothing handshake: ready only if something is addressed and
    // every addressed PE is ready; suppressed while the chain is shifting.
    always_comb begin
        ready_s  = 1'b0;
        enable_s = {NUM_PE{1'b0}};
        if (!program_en) begin
            ready_s  = (|hit_s) & (&(pe_ready | ~hit_s));
            enable_s = {NUM_PE{gin_enable & ready_s}} & hit_s;
        end else begin
            ready_s  = 1'b0;
            enable_s = {NUM_PE{1'b0}};
        end
    end

    assign gin_ready    = ready_s;
    assign pe_enable    = enable_s;
    assign scan_tag_out = chain_r[0];

    // PE value registers: capture the data word on a transfer strobe.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pe_value <= {(BITWIDTH*NUM_PE){1'b0}};
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (enable_s[k]) begin
                    pe_value[BITWIDTH*k +: BITWIDTH] <= data_s;
                end else begin
                    pe_value[BITWIDTH*k +: BITWIDTH] <= pe_value[BITWIDTH*k +: BITWIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_gin.sv
// -----------------------------------------------------------------------------
// tb_gin - self-checking testbench for gin (default 16-bit data, 4-bit tags,
// 4x4 PE array). Inputs change on the falling edge; combinational outputs are
// sampled 1 ns later and registered outputs on the following falling edge.
// -----------------------------------------------------------------------------
module tb_gin;

    logic          clk;
    logic          rstb;
    logic          program_en;
    logic [3:0]    scan_tag_in;
    logic [3:0]    scan_tag_out;
    logic          gin_enable;
    logic          gin_ready;
    logic [23:0]   data_packet;
    logic [15:0]   pe_enable;
    logic [15:0]   pe_ready;
    logic [255:0]  pe_value;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_val [16];
    logic [15:0] one16;

    gin #(
        .BITWIDTH  (16),
        .TAG_LENGTH(4),
        .X_BUS_SIZE(4),
        .Y_BUS_SIZE(4)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .program_en  (program_en),
        .scan_tag_in (scan_tag_in),
        .scan_tag_out(scan_tag_out),
        .gin_enable  (gin_enable),
        .gin_ready   (gin_ready),
        .data_packet (data_packet),
        .pe_enable   (pe_enable),
        .pe_ready    (pe_ready),
        .pe_value    (pe_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push one word into the scan chain on the next rising edge.
    task automatic shift_word(input logic [3:0] w);
        @(negedge clk);
        program_en  = 1'b1;
        scan_tag_in = w;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rstb        = 1'b0;
        program_en  = 1'b0;
        scan_tag_in = 4'd0;
        gin_enable  = 1'b0;
        data_packet = {4'd0, 4'd0, 16'h0000};
        pe_ready    = 16'hFFFF;
        for (int k = 0; k < 16; k++) exp_val[k] = 16'h0000;
        #12;
        checks++;
        if (scan_tag_out !== 4'd0) begin
            failures++;
            $display("FAIL reset_scan_out: got %0d want 0", scan_tag_out);
        end
        checks++;
        if (pe_value !== 256'd0) begin
            failures++;
            $display("FAIL reset_pe_value: got %h want 0", pe_value);
        end
        // IDs are zero, so tag 0/0 addresses everything even during reset.
        checks++;
        if (gin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_gin_ready: got %b want 1", gin_ready);
        end
        checks++;
        if (pe_enable !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pe_enable: got %h want 0000", pe_enable);
        end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_program();
        logic [3:0] seq [20];
        logic [3:0] yid [4];
        logic [3:0] xid [4][4];
        seq = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd5, 4'd4, 4'd3, 4'd2, 4'd4, 4'd3,
                4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
        yid = '{4'd6, 4'd5, 4'd4, 4'd3};
        xid = '{'{4'd5, 4'd4, 4'd3, 4'd2}, '{4'd4, 4'd3, 4'd2, 4'd1},
                '{4'd3, 4'd2, 4'd1, 4'd0}, '{4'd3, 4'd2, 4'd1, 4'd0}};
        // While shifting, a packet that would match the reset IDs is blocked.
        @(negedge clk);
        program_en  = 1'b1;
        scan_tag_in = seq[0];
        gin_enable  = 1'b1;
        data_packet = {4'd0, 4'd0, 16'h5A5A};
        #1;
        checks++;
        if (gin_ready !== 1'b0 || pe_enable !== 16'h0000) begin
            failures++;
            $display("FAIL program_blocks: got ready=%b en=%h want 0/0000", gin_ready, pe_enable);
        end
        @(posedge clk);
        for (int i = 1; i < 20; i++) shift_word(seq[i]);
        @(negedge clk);
        program_en = 1'b0;
        gin_enable = 1'b0;
        #1;
        checks++;
        if (scan_tag_out !== 4'd6) begin
            failures++;
            $display("FAIL program_scan_out: got %0d want 6", scan_tag_out);
        end
        // Each (row ID, column ID) pair must strobe exactly its own PE.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                data_packet = {yid[r], xid[r][c], 16'h0000};
                gin_enable  = 1'b1;
                #1;
                checks++;
                if (gin_ready !== 1'b1 || pe_enable !== (one16 << (r*4+c))) begin
                    failures++;
                    $display("FAIL program_map_r%0d_c%0d: got ready=%b en=%h want 1/%h",
                             r, c, gin_ready, pe_enable, one16 << (r*4+c));
                end
                gin_enable = 1'b0;
            end
        end
    endtask

    task automatic test_unicast();
        @(negedge clk);
        data_packet = {4'd3, 4'd0, 16'hFFFF};
        gin_enable  = 1'b1;
        pe_ready    = 16'hFFFF;
        #1;
        checks++;
        if (gin_ready !== 1'b1 || pe_enable !== 16'h8000) begin
            failures++;
            $display("FAIL unicast_strobe: got ready=%b en=%h want 1/8000", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable  = 1'b0;
        exp_val[15] = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (pe_value[16*k +: 16] !== exp_val[k]) begin
                failures++;
                $display("FAIL unicast_value_%0d: got %h want %h", k, pe_value[16*k +: 16], exp_val[k]);
            end
        end
    endtask

    task automatic test_no_match();
        @(negedge clk);
        data_packet = {4'd0, 4'd0, 16'hABCD};
        gin_enable  = 1'b1;
        #1;
        checks++;
        if (gin_ready !== 1'b0 || pe_enable !== 16'h0000) begin
            failures++;
            $display("FAIL nomatch_strobe: got ready=%b en=%h want 0/0000", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (pe_value[16*k +: 16] !== exp_val[k]) begin
                failures++;
                $display("FAIL nomatch_value_%0d: got %h want %h", k, pe_value[16*k +: 16], exp_val[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rstb = 1'b0;
        #2;
        for (int k = 0; k < 16; k++) exp_val[k] = 16'h0000;
        checks++;
        if (pe_value !== 256'd0) begin
            failures++;
            $display("FAIL midreset_pe_value: got %h want 0", pe_value);
        end
        checks++;
        if (scan_tag_out !== 4'd0) begin
            failures++;
            $display("FAIL midreset_scan_out: got %0d want 0", scan_tag_out);
        end
        rstb = 1'b1;
        @(negedge clk);
        data_packet = {4'd0, 4'd0, 16'hBEEF};
        gin_enable  = 1'b1;
        #1;
        checks++;
        if (gin_ready !== 1'b1 || pe_enable !== 16'hFFFF) begin
            failures++;
            $display("FAIL midreset_broadcast: got ready=%b en=%h want 1/ffff", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable = 1'b0;
        for (int k = 0; k < 16; k++) exp_val[k] = 16'hBEEF;
        checks++;
        if (pe_value !== {16{16'hBEEF}}) begin
            failures++;
            $display("FAIL midreset_values: got %h want all beef", pe_value);
        end
    endtask

    task automatic test_multicast();
        for (int i = 0; i < 20; i++) shift_word(4'd0);
        @(negedge clk);
        program_en  = 1'b0;
        data_packet = {4'd0, 4'd0, 16'h1234};
        gin_enable  = 1'b1;
        pe_ready    = 16'hFFFF;
        #1;
        checks++;
        if (gin_ready !== 1'b1 || pe_enable !== 16'hFFFF) begin
            failures++;
            $display("FAIL multicast_strobe: got ready=%b en=%h want 1/ffff", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_val[k] = 16'h1234;
            checks++;
            if (pe_value[16*k +: 16] !== exp_val[k]) begin
                failures++;
                $display("FAIL multicast_value_%0d: got %h want %h", k, pe_value[16*k +: 16], exp_val[k]);
            end
        end
        // One addressed PE not ready blocks the whole multicast.
        @(negedge clk);
        pe_ready    = 16'hFFDF;
        data_packet = {4'd0, 4'd0, 16'h5555};
        gin_enable  = 1'b1;
        #1;
        checks++;
        if (gin_ready !== 1'b0 || pe_enable !== 16'h0000) begin
            failures++;
            $display("FAIL multicast_blocked: got ready=%b en=%h want 0/0000", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable = 1'b0;
        pe_ready   = 16'hFFFF;
        checks++;
        if (pe_value !== {16{16'h1234}}) begin
            failures++;
            $display("FAIL multicast_held: got %h want all 1234", pe_value);
        end
    endtask

    task automatic test_wildcard();
        logic [3:0] seq [20];
        // Y rows 7,8,15,10; xbus2 = 0,1,2,3; other X buses 0.
        seq = '{4'd7, 4'd8, 4'd15, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 20; i++) shift_word(seq[i]);
        @(negedge clk);
        program_en = 1'b0;
        // An exact all-ones tag matches row 2 in either build.
        data_packet = {4'd15, 4'd1, 16'h0F0F};
        gin_enable  = 1'b1;
        #1;
        checks++;
        if (gin_ready !== 1'b1 || pe_enable !== 16'h0200) begin
            failures++;
            $display("FAIL wild_exact15: got ready=%b en=%h want 1/0200", gin_ready, pe_enable);
        end
        gin_enable = 1'b0;
        @(negedge clk);
        data_packet = {4'd9, 4'd1, 16'h0909};
        gin_enable  = 1'b1;
        #1;
`ifdef GIN_TAG_WILDCARD_EN
        checks++;
        if (gin_ready !== 1'b1 || pe_enable !== 16'h0200) begin
            failures++;
            $display("FAIL wild_row9: got ready=%b en=%h want 1/0200", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable = 1'b0;
        exp_val[9] = 16'h0909;
        checks++;
        if (pe_value[16*9 +: 16] !== exp_val[9] || pe_value[16*8 +: 16] !== exp_val[8]) begin
            failures++;
            $display("FAIL wild_value: got pe9=%h pe8=%h want %h/%h",
                     pe_value[16*9 +: 16], pe_value[16*8 +: 16], exp_val[9], exp_val[8]);
        end
`else
        checks++;
        if (gin_ready !== 1'b0 || pe_enable !== 16'h0000) begin
            failures++;
            $display("FAIL wild_off_row9: got ready=%b en=%h want 0/0000", gin_ready, pe_enable);
        end
        @(negedge clk);
        gin_enable = 1'b0;
        checks++;
        if (pe_value !== {16{16'h1234}}) begin
            failures++;
            $display("FAIL wild_off_values: got %h want all 1234", pe_value);
        end
`endif
    endtask

    initial begin
        one16 = 16'h0001;
        test_reset();
        test_program();
        test_unicast();
        test_no_match();
        test_reset_mid();
        test_multicast();
        test_wildcard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
